// File: rtl/adpcm_pkg.sv
// adpcm_pkg: shared constants and types for the multi-channel IMA ADPCM decoder.
//   STEP_TABLE  - IMA step sizes indexed by step index 0..88
//   INDEX_ADJ   - step-index adjustment per code magnitude c[2:0]
//   MAX_INDEX   - largest legal step index
//   chan_state_t- per-channel predictor/index state
//   fsm_t       - output sequencer states
package adpcm_pkg;

  localparam int unsigned MAX_INDEX = 88;

  localparam logic [15:0] STEP_TABLE [89] = '{
    16'd7,     16'd8,     16'd9,     16'd10,    16'd11,    16'd12,    16'd13,    16'd14,    16'd16,    16'd17,
    16'd19,    16'd21,    16'd23,    16'd25,    16'd28,    16'd31,    16'd34,    16'd37,    16'd41,    16'd45,
    16'd50,    16'd55,    16'd60,    16'd66,    16'd73,    16'd80,    16'd88,    16'd97,    16'd107,   16'd118,
    16'd130,   16'd143,   16'd157,   16'd173,   16'd190,   16'd209,   16'd230,   16'd253,   16'd279,   16'd307,
    16'd337,   16'd371,   16'd408,   16'd449,   16'd494,   16'd544,   16'd598,   16'd658,   16'd724,   16'd796,
    16'd876,   16'd963,   16'd1060,  16'd1166,  16'd1282,  16'd1411,  16'd1552,  16'd1707,  16'd1878,  16'd2066,
    16'd2272,  16'd2499,  16'd2749,  16'd3024,  16'd3327,  16'd3660,  16'd4026,  16'd4428,  16'd4871,  16'd5358,
    16'd5894,  16'd6484,  16'd7132,  16'd7845,  16'd8630,  16'd9493,  16'd10442, 16'd11487, 16'd12635, 16'd13899,
    16'd15289, 16'd16818, 16'd18500, 16'd20350, 16'd22385, 16'd24623, 16'd27086, 16'd29794, 16'd32767
  };

  localparam logic signed [7:0] INDEX_ADJ [8] = '{
    -8'sd1, -8'sd1, -8'sd1, -8'sd1, 8'sd2, 8'sd4, 8'sd6, 8'sd8
  };

  typedef struct packed {
    logic [15:0] pred;   // two's complement predictor
    logic [6:0]  index;  // step index, 0..MAX_INDEX
  } chan_state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OUT1,
    S_OUT2
  } fsm_t;

  function automatic logic [6:0] clamp_index(input logic [6:0] idx);
    return (idx > 7'(MAX_INDEX)) ? 7'(MAX_INDEX) : idx;
  endfunction

endpackage

// File: rtl/adpcm_mc_decoder_nibble_step.sv
// adpcm_nibble_step: combinational single-code IMA ADPCM update.
//   pred/index  - current channel state (index assumed 0..88)
//   code        - 4-bit ADPCM code (bit 3 = sign)
//   next_pred   - saturated new predictor
//   next_index  - clamped new step index
module adpcm_nibble_step
  import adpcm_pkg::*;
(
  input  logic [15:0] pred,
  input  logic [6:0]  index,
  input  logic [3:0]  code,
  output logic [15:0] next_pred,
  output logic [6:0]  next_index
);

  logic [15:0]       step;
  logic [17:0]       diff;
  logic signed [17:0] sum;
  logic signed [7:0]  idx_sum;

  always_comb begin
    step = STEP_TABLE[index];
    diff = {5'b0, step[15:3]};
    if (code[2]) diff = diff + {2'b0, step};
    if (code[1]) diff = diff + {3'b0, step[15:1]};
    if (code[0]) diff = diff + {4'b0, step[15:2]};

    // diff < 2^17, so an 18-bit signed sum cannot wrap before saturation
    if (code[3]) sum = $signed({{2{pred[15]}}, pred}) - $signed(diff);
    else         sum = $signed({{2{pred[15]}}, pred}) + $signed(diff);

    if (sum > 18'sd32767)       next_pred = 16'h7FFF;
    else if (sum < -18'sd32768) next_pred = 16'h8000;
    else                        next_pred = sum[15:0];

    idx_sum = $signed({1'b0, index}) + INDEX_ADJ[code[2:0]];
    if (idx_sum < 8'sd0)       next_index = '0;
    else if (idx_sum > 8'sd88) next_index = 7'(MAX_INDEX);
    else                       next_index = idx_sum[6:0];
  end

endmodule

// File: rtl/adpcm_mc_decoder.sv
// adpcm_mc_decoder: multi-channel stream IMA ADPCM decoder.
//   clk, reset          - clock; asynchronous active-low reset
//   in_valid/in_ready   - code byte handshake; in_data holds two codes,
//                         in_ch selects the channel (>= NUM_CH is dropped)
//   init_*              - one-cycle seed of a channel's pred/index
//   out_valid/out_ready - sample handshake; out_sample/out_ch held while stalled
module adpcm_mc_decoder
  import adpcm_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter bit          HI_FIRST = 1'b0,
  parameter int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_data,
  input  logic [CH_W-1:0] in_ch,
  input  logic            init_valid,
  input  logic [CH_W-1:0] init_ch,
  input  logic [15:0]     init_pred,
  input  logic [6:0]      init_index,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_sample,
  output logic [CH_W-1:0] out_ch
);

  fsm_t            state_q, state_d;
  chan_state_t     ch_q [NUM_CH];
  logic [3:0]      pend_code_q;
  logic [CH_W-1:0] pend_ch_q;

  logic            ch_ok;
  logic            accept;
  logic            dec_en;
  logic            dec_from_in;
  logic [CH_W-1:0] dec_ch;
  logic [3:0]      dec_code;
  chan_state_t     dec_cur;
  logic [15:0]     dec_pred;
  logic [6:0]      dec_index;
  logic [3:0]      first_nib, second_nib;

  generate
    if (NUM_CH == (1 << CH_W)) begin : g_full_range
      assign ch_ok = 1'b1;
    end else begin : g_part_range
      assign ch_ok = (in_ch < CH_W'(NUM_CH));
    end
  endgenerate

  assign first_nib  = HI_FIRST ? in_data[7:4] : in_data[3:0];
  assign second_nib = HI_FIRST ? in_data[3:0] : in_data[7:4];

  assign in_ready  = reset && ((state_q == S_IDLE) || ((state_q == S_OUT2) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q != S_IDLE);

  // Accept and second-nibble decode never coincide, so one step unit suffices.
  assign dec_ch   = dec_from_in ? in_ch : pend_ch_q;
  assign dec_code = dec_from_in ? first_nib : pend_code_q;
  assign dec_cur  = ch_q[dec_ch];

  adpcm_nibble_step u_step (
    .pred       (dec_cur.pred),
    .index      (dec_cur.index),
    .code       (dec_code),
    .next_pred  (dec_pred),
    .next_index (dec_index)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    dec_en      = 1'b0;
    dec_from_in = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (ch_ok) begin
            dec_en      = 1'b1;
            dec_from_in = 1'b1;
            state_d     = S_OUT1;
          end
        end
      end
      S_OUT1: begin
        if (out_ready) begin
          dec_en  = 1'b1;
          state_d = S_OUT2;
        end
      end
      S_OUT2: begin
        if (out_ready) begin
          state_d = S_IDLE;
          if (accept && ch_ok) begin
            dec_en      = 1'b1;
            dec_from_in = 1'b1;
            state_d     = S_OUT1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_sample  <= '0;
      out_ch      <= '0;
      pend_code_q <= '0;
      pend_ch_q   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
    end else begin
      if (dec_en) begin
        out_sample <= dec_pred;
        out_ch     <= dec_ch;
      end
      if (accept && ch_ok) begin
        pend_code_q <= second_nib;
        pend_ch_q   <= in_ch;
      end
      // Init overrides a same-cycle decode write-back on the same channel.
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (init_valid && (init_ch == CH_W'(i))) begin
          ch_q[i] <= '{pred: init_pred, index: clamp_index(init_index)};
        end else if (dec_en && (dec_ch == CH_W'(i))) begin
          ch_q[i] <= '{pred: dec_pred, index: dec_index};
        end
      end
    end
  end

endmodule

// File: doc/adpcm_mc_decoder.md
# adpcm_mc_decoder

Multi-channel, stream-based IMA ADPCM decoder: the parametrised successor of the single-channel per-clock nibble decoder. It accepts packed code bytes (two 4-bit codes each) tagged with a channel number over a valid/ready handshake, and keeps independent predictor/index state per channel. It emits one saturated 16-bit PCM sample per accepted nibble with output backpressure. Sits between the container/byte parser (which also supplies per-block header seeds through the init port) and the audio output FIFO.

## Interface
- NUM_CH, 2: number of independent channels, ≥1; CH_W = max(1, $clog2(NUM_CH)).
- HI_FIRST, 0: 0 = low nibble decoded first (IMA/WAV order); 1 = high nibble first.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  code byte valid.
- in_ready  out  1  decoder accepts byte.
- in_data  in  8  two packed 4-bit codes.
- in_ch  in  CH_W  channel of in_data; values ≥ NUM_CH are dropped (byte consumed, no output).
- init_valid  in  1  one-cycle write of channel state.
- init_ch  in  CH_W  channel to seed.
- init_pred  in  16  signed seed predictor.
- init_index  in  7  seed step index; values >88 are clamped to 88.
- out_valid  out  1  sample valid.
- out_ready  in  1  consumer accepts sample.
- out_sample  out  16  signed PCM sample.
- out_ch  out  CH_W  channel of out_sample.

## Operation
- Per-channel state: pred[ch] (signed 16), index[ch] (0..88). Reset: all 0.
- Decode of code c with step = STEP_TABLE[index]: diff = (step>>3) + (c[2]?step:0) + (c[1]?step>>1:0) + (c[0]?step>>2:0), computed at 18 bits; new pred = c[3] ? pred−diff : pred+diff, saturated to [−32768, 32767]; new index = index + INDEX_ADJ[c[2:0]] (−1,−1,−1,−1,2,4,6,8), clamped to [0, 88].
- FSM: IDLE → (byte accepted) OUT1 → (out_ready) OUT2 → (out_ready) IDLE, or straight to OUT1 if a new byte is accepted in the same cycle.
- On accept: first nibble decoded from channel state; out_sample/out_ch registered; channel state updated; second nibble latched.
- OUT1 with out_ready: second nibble decoded from updated state, registered, state updated.
- in_ready = reset_deasserted && (IDLE || (OUT2 && out_ready)). Throughput: 1 sample/cycle sustained.
- Init: applied on any cycle with init_valid. On the same cycle and channel as a decode update, init wins; a pending second nibble of that channel then decodes from the init values.
- Dropped byte (in_ch ≥ NUM_CH): FSM stays in or returns to IDLE; out_valid is 0.

## Timing
- Reset values: out_valid 0, out_sample 0, out_ch 0, FSM IDLE, in_ready 0 while reset is asserted.
- Latency: the first sample appears on out_valid the cycle after the accept edge. The second sample appears the cycle after the first sample's handshake.
- out_sample/out_ch hold stable while out_valid && !out_ready.
- Reset assertion mid-byte: the pending nibble is discarded. out_valid deasserts asynchronously, and all channel state returns to 0.

## Structure
- adpcm_pkg: STEP_TABLE[89] (16-bit, 7…32767), INDEX_ADJ[8], MAX_INDEX = 88, and a typedef for chan_state_t {pred, index}.
- Sub-module adpcm_nibble_step: combinational (pred, index, code) → (next_pred, next_index), including saturation and clamping.
- Top: FSM, state array, handshake, init arbitration.

## Test plan
- After reset, ch0 byte 0x77 → samples 11 then 41; index[ch0] = 16.
- After reset, ch1 byte 0x00 → samples 0, 0; index stays 0 (clamp at 0); ch0 state is unaffected.
- Init ch0 pred −30000, index 88; byte 0xFF → −32768, −32768 (saturation). Init pred 32767, index 100; byte 0x77 → 32767, 32767, with index held at 88.
- Back-to-back bytes alternating ch0 and ch1 with out_ready = 1 → one sample per cycle, in_ready high every second cycle. Repeat with out_ready toggled randomly → no loss, no duplicates, outputs held stable.
- Init on ch0 in the same cycle as the first-sample update of a ch0 byte → second sample computed from the init values.
- Reset asserted in OUT1 → out_valid is 0 immediately. After release, byte 0x77 on ch0 → 11, 41.
